// File: rtl/hack_cpu_ctrl.sv
// Multicycle control/register stage of a 16-bit Hack-style CPU: owns PC/A/D/IR, sequences
// fetch, optional M read, single-cycle ALU execute and optional M write over valid/ack handshakes.
module hack_cpu_ctrl #(
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic            dmem_re,
  output logic            dmem_we,
  output logic [PC_W-1:0] dmem_addr,
  output logic [15:0]     dmem_wdata,
  input  logic [15:0]     dmem_rdata,
  input  logic            dmem_ack,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic [5:0]      alu_ctrl,
  input  logic [15:0]     alu_o,
  input  logic            alu_zr,
  input  logic            alu_ng,
  output logic [15:0]     reg_a,
  output logic [15:0]     reg_d,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_RDM    = 3'd2,
    S_EXEC   = 3'd3,
    S_WRM    = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [15:0]     a_q, a_nxt;
  logic [15:0]     d_q, d_nxt;
  logic [15:0]     ir_q, ir_nxt;
  logic [15:0]     m_q, m_nxt;
  logic [PC_W-1:0] wa_q, wa_nxt;
  logic [15:0]     wd_q, wd_nxt;

  logic            is_c;
  logic            ir_a;
  logic [2:0]      ir_d;
  logic [2:0]      ir_j;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] a_addr;
  logic            jump_taken;

  assign is_c   = ir_q[15];
  assign ir_a   = ir_q[12];
  assign ir_d   = ir_q[5:3];
  assign ir_j   = ir_q[2:0];
  assign pc_inc = pc_q + PC_W'(1);
  // A is untouched until the EXEC edge, so a_q is always the instruction-start value here.
  assign a_addr = PC_W'(a_q);

  assign jump_taken = (ir_j[2] & alu_ng)
                    | (ir_j[1] & alu_zr)
                    | (ir_j[0] & ~alu_ng & ~alu_zr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc_q  <= RESET_PC;
      a_q   <= '0;
      d_q   <= '0;
      ir_q  <= '0;
      m_q   <= '0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      a_q   <= a_nxt;
      d_q   <= d_nxt;
      ir_q  <= ir_nxt;
      m_q   <= m_nxt;
      wa_q  <= wa_nxt;
      wd_q  <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    a_nxt     = a_q;
    d_nxt     = d_q;
    ir_nxt    = ir_q;
    m_nxt     = m_q;
    wa_nxt    = wa_q;
    wd_nxt    = wd_q;
    case (state)
      S_FETCH: begin
        if (imem_valid) begin
          ir_nxt    = imem_data;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!is_c) begin
          a_nxt     = {1'b0, ir_q[14:0]};
          pc_nxt    = pc_inc;
          state_nxt = S_FETCH;
        end else if (ir_a) begin
          state_nxt = S_RDM;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_RDM: begin
        if (dmem_ack) begin
          m_nxt     = dmem_rdata;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ir_d[2]) a_nxt = alu_o;
        if (ir_d[1]) d_nxt = alu_o;
        pc_nxt = jump_taken ? a_addr : pc_inc;
        if (ir_d[0]) begin
          wa_nxt    = a_addr;
          wd_nxt    = alu_o;
          state_nxt = S_WRM;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_WRM: begin
        if (dmem_ack) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Strobes decode purely from state, so reset or an ack edge drops them the next cycle.
  always_comb begin
    imem_req   = (state == S_FETCH);
    imem_addr  = pc_q;
    dmem_re    = (state == S_RDM);
    dmem_we    = (state == S_WRM);
    dmem_addr  = (state == S_RDM) ? a_addr : wa_q;
    dmem_wdata = wd_q;
    alu_x      = d_q;
    alu_y      = ir_a ? m_q : a_q;
    alu_ctrl   = ir_q[11:6];
  end

  assign reg_a = a_q;
  assign reg_d = d_q;
  assign pc    = pc_q;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: behavioural Hack ALU plus per-scenario tasks that play memory.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        dmem_re;
  logic        dmem_we;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctrl;
  logic [15:0] alu_o;
  logic        alu_zr;
  logic        alu_ng;
  logic [15:0] reg_a;
  logic [15:0] reg_d;
  logic [14:0] pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.PC_W(15), .RESET_PC(15'd0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
    .alu_o(alu_o), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .reg_a(reg_a), .reg_d(reg_d), .pc(pc)
  );

  // Standard Hack ALU: {zx,nx,zy,ny,f,no}
  logic [15:0] mx, my, mr;
  always_comb begin
    mx = alu_x;
    my = alu_y;
    if (alu_ctrl[5]) mx = '0;
    if (alu_ctrl[4]) mx = ~mx;
    if (alu_ctrl[3]) my = '0;
    if (alu_ctrl[2]) my = ~my;
    mr = alu_ctrl[1] ? (mx + my) : (mx & my);
    if (alu_ctrl[0]) mr = ~mr;
    alu_o  = mr;
    alu_zr = (mr == 16'h0000);
    alu_ng = mr[15];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Serves one instruction starting in FETCH; returns once the next fetch request appears.
  task automatic run_instr(input logic [15:0] instr, input logic [15:0] rdata, input int waits,
                           output int cycles, output int we_cycles, output logic [14:0] waddr,
                           output logic [15:0] wdata, output logic [15:0] ysamp);
    int  rw, ww;
    bit  fetched, after_rd, done;
    cycles = 0; we_cycles = 0; rw = 0; ww = 0;
    fetched = 0; after_rd = 0; done = 0;
    waddr = '0; wdata = '0; ysamp = '0;
    for (int k = 0; k < 64 && !done; k++) begin
      imem_valid = 1'b0;
      dmem_ack   = 1'b0;
      if (after_rd) ysamp = alu_y;
      after_rd = 0;
      if (imem_req && fetched) begin
        done = 1;
      end else begin
        if (imem_req) begin
          imem_valid = 1'b1;
          imem_data  = instr;
          fetched    = 1;
        end
        if (dmem_re) begin
          if (rw == waits) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
            after_rd   = 1;
          end
          rw++;
        end
        if (dmem_we) begin
          we_cycles++;
          waddr = dmem_addr;
          wdata = dmem_wdata;
          if (ww == waits) dmem_ack = 1'b1;
          ww++;
        end
        step();
        cycles++;
      end
    end
    imem_valid = 1'b0;
    dmem_ack   = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL run_instr_timeout instr=%h got=no_fetch exp=fetch_within_64", instr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    chk("rst_imem_req", {15'd0, imem_req}, 16'd1);
    chk("rst_dmem_re",  {15'd0, dmem_re},  16'd0);
    chk("rst_dmem_we",  {15'd0, dmem_we},  16'd0);
    chk("rst_pc",       {1'b0, pc},        16'd0);
    chk("rst_a",        reg_a,             16'd0);
    chk("rst_d",        reg_d,             16'd0);
    chk("rst_alu_ctrl", {10'd0, alu_ctrl}, 16'd0);
    rst = 1'b0;
  endtask

  task automatic test_a_load();
    int cyc, wec; logic [14:0] wa; logic [15:0] wd, ys;
    do_reset();
    run_instr(16'h1234, 16'h0, 0, cyc, wec, wa, wd, ys);
    chk("aload_a",      reg_a,             16'h1234);
    chk("aload_pc",     {1'b0, pc},        16'd1);
    chk("aload_cycles", 16'(cyc),          16'd2);
    chk("aload_req",    {15'd0, imem_req}, 16'd1);
    chk("aload_iaddr",  {1'b0, imem_addr}, 16'd1);
  endtask

  task automatic test_alu_write();
    int cyc, wec; logic [14:0] wa; logic [15:0] wd, ys;
    do_reset();
    run_instr(16'h0005, 16'h0, 0, cyc, wec, wa, wd, ys);
    run_instr(16'hEDD0, 16'h0, 0, cyc, wec, wa, wd, ys);
    chk("dinc_d",      reg_d,    16'd6);
    chk("dinc_cycles", 16'(cyc), 16'd3);
    run_instr(16'hE308, 16'h0, 3, cyc, wec, wa, wd, ys);
    chk("mwr_we_cycles", 16'(wec),   16'd4);
    chk("mwr_addr",      {1'b0, wa}, 16'd5);
    chk("mwr_wdata",     wd,         16'd6);
    chk("mwr_cycles",    16'(cyc),   16'd7);
    chk("mwr_pc",        {1'b0, pc}, 16'd3);
    chk("mwr_we_low",    {15'd0, dmem_we}, 16'd0);
  endtask

  task automatic test_read_path();
    int cyc, wec; logic [14:0] wa; logic [15:0] wd, ys;
    do_reset();
    run_instr(16'h0007, 16'h0, 0, cyc, wec, wa, wd, ys);
    run_instr(16'hFC10, 16'hBEEF, 2, cyc, wec, wa, wd, ys);
    chk("rd_alu_y",  ys,        16'hBEEF);
    chk("rd_d",      reg_d,     16'hBEEF);
    chk("rd_cycles", 16'(cyc),  16'd6);
    chk("rd_no_we",  16'(wec),  16'd0);
    chk("rd_a_kept", reg_a,     16'h0007);
  endtask

  task automatic test_jumps();
    int cyc, wec; logic [14:0] wa; logic [15:0] wd, ys;
    do_reset();
    run_instr(16'hEE90, 16'h0, 0, cyc, wec, wa, wd, ys);
    chk("jmp_dneg", reg_d, 16'hFFFF);
    run_instr(16'h0010, 16'h0, 0, cyc, wec, wa, wd, ys);
    run_instr(16'hE304, 16'h0, 0, cyc, wec, wa, wd, ys);
    chk("jlt_taken_pc", {1'b0, pc}, 16'h0010);
    run_instr(16'hEA90, 16'h0, 0, cyc, wec, wa, wd, ys);
    run_instr(16'h0010, 16'h0, 0, cyc, wec, wa, wd, ys);
    run_instr(16'hE304, 16'h0, 0, cyc, wec, wa, wd, ys);
    chk("jlt_zero_pc", {1'b0, pc}, 16'h0013);
    run_instr(16'hEA87, 16'h0, 0, cyc, wec, wa, wd, ys);
    chk("jmp_pc",     {1'b0, pc}, 16'h0010);
    chk("jmp_cycles", 16'(cyc),   16'd3);
  endtask

  task automatic test_am_dec();
    int cyc, wec; logic [14:0] wa; logic [15:0] wd, ys;
    do_reset();
    run_instr(16'h0003, 16'h0, 0, cyc, wec, wa, wd, ys);
    run_instr(16'hFCA8, 16'h0009, 0, cyc, wec, wa, wd, ys);
    chk("am_a",      reg_a,      16'd8);
    chk("am_waddr",  {1'b0, wa}, 16'd3);
    chk("am_wdata",  wd,         16'd8);
    chk("am_d",      reg_d,      16'd0);
    chk("am_cycles", 16'(cyc),   16'd5);
  endtask

  task automatic test_reset_mid_wrm();
    int cyc, wec; logic [14:0] wa; logic [15:0] wd, ys;
    bit seen;
    do_reset();
    run_instr(16'h0005, 16'h0, 0, cyc, wec, wa, wd, ys);
    run_instr(16'hEDD0, 16'h0, 0, cyc, wec, wa, wd, ys);
    imem_valid = 1'b1;
    imem_data  = 16'hE308;
    step();
    imem_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (dmem_we) seen = 1;
      else step();
    end
    chk("mid_we_seen", {15'd0, seen}, 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_we_low", {15'd0, dmem_we},  16'd0);
    chk("mid_pc",     {1'b0, pc},        16'd0);
    chk("mid_a",      reg_a,             16'd0);
    chk("mid_d",      reg_d,             16'd0);
    chk("mid_fetch",  {15'd0, imem_req}, 16'd1);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("late_ack_req", {15'd0, imem_req}, 16'd1);
    chk("late_ack_we",  {15'd0, dmem_we},  16'd0);
    chk("late_ack_pc",  {1'b0, pc},        16'd0);
  endtask

  task automatic test_pc_wrap();
    int cyc, wec; logic [14:0] wa; logic [15:0] wd, ys;
    do_reset();
    run_instr(16'h7FFF, 16'h0, 0, cyc, wec, wa, wd, ys);
    run_instr(16'hEA87, 16'h0, 0, cyc, wec, wa, wd, ys);
    chk("wrap_pre_pc", {1'b0, pc}, 16'h7FFF);
    run_instr(16'h0001, 16'h0, 0, cyc, wec, wa, wd, ys);
    chk("wrap_pc",    {1'b0, pc},        16'h0000);
    chk("wrap_iaddr", {1'b0, imem_addr}, 16'h0000);
    chk("wrap_a",     reg_a,             16'h0001);
  endtask

  initial begin
    rst        = 1'b1;
    imem_valid = 1'b0;
    imem_data  = '0;
    dmem_rdata = '0;
    dmem_ack   = 1'b0;
    test_reset();
    test_a_load();
    test_alu_write();
    test_read_path();
    test_jumps();
    test_am_dec();
    test_reset_mid_wrm();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
